fifo_wr_ctrl: RTL and testbench

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_wr_ctrl_if.sv | 25 ++
 rtl/ptr_sync.sv | 26 ++
 rtl/fifo_wr_ctrl.sv | 86 ++++++++
 tb/tb_fifo_wr_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers for the write- and read-side controllers: default widths and Gray conversions.
// Conversions work on a 32-bit word; callers zero-extend their pointer and size-cast the result back.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 3;
  localparam int PTR_W_DEF      = ADDR_WIDTH_DEF + 1;

  typedef logic [31:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, done as a log-depth shift cascade.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = g ^ (g >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Producer-side bundle of the FIFO write controller; W_ALMOST_FULL exists only with FIFO_WR_ALMOST_FULL_EN.
// master = producer (drives W_INC), slave = controller.
interface fifo_wr_ctrl_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  W_INC;
  logic                  W_CLKEN;
  logic [ADDR_WIDTH-1:0] W_ADDR;
  logic                  W_FULL;
  logic [ADDR_WIDTH:0]   W_LEVEL;

`ifdef FIFO_WR_ALMOST_FULL_EN
  logic                  W_ALMOST_FULL;

  modport master (output W_INC, input W_CLKEN, W_ADDR, W_FULL, W_LEVEL, W_ALMOST_FULL);
  modport slave  (input W_INC, output W_CLKEN, W_ADDR, W_FULL, W_LEVEL, W_ALMOST_FULL);
`else
  modport master (output W_INC, input W_CLKEN, W_ADDR, W_FULL, W_LEVEL);
  modport slave  (input W_INC, output W_CLKEN, W_ADDR, W_FULL, W_LEVEL);
`endif

endinterface

// File: rtl/ptr_sync.sv
// Two-flop synchronizer bringing a Gray pointer into the local clock domain, synchronous active-high reset.
// Latency 2 clk edges; no flow control.
module ptr_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH = PTR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async-FIFO write-side controller: pointers, Gray export, registered full, conservative level; optional FIFO_WR_ALMOST_FULL_EN.
// Write lands on the edge W_INC is seen (0 latency); W_INC while W_FULL is dropped silently.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AF_MARGIN  = 2
) (
  input  logic              W_CLK,
  input  logic              W_RST,
  fifo_wr_ctrl_if.slave     wr,
  input  logic [ADDR_WIDTH:0] R_PTR_GRAY,
  output logic [ADDR_WIDTH:0] W_PTR_GRAY
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_ptr;
  logic          w_full;
  logic          w_clken;
  logic          full_next;

  ptr_sync #(.WIDTH(PW)) u_rptr_sync (
    .clk (W_CLK),
    .rst (W_RST),
    .d   (R_PTR_GRAY),
    .q   (rq2)
  );

  assign w_clken    = wr.W_INC & ~w_full & ~W_RST;
  assign wbin_next  = wbin + PW'(w_clken);
  assign wgray_next = PW'(bin2gray(ptr_word_t'(wbin_next)));
  assign rbin       = PW'(gray2bin(ptr_word_t'(rq2)));

  // Full when the writer is exactly one lap ahead: top two Gray bits inverted, rest equal.
  assign full_ptr   = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
  assign full_next  = (wgray_next == full_ptr);

  always_ff @(posedge W_CLK) begin
    if (W_RST) begin
      wbin   <= '0;
      wgray  <= '0;
      w_full <= 1'b0;
    end else begin
      wbin   <= wbin_next;
      wgray  <= wgray_next;
      w_full <= full_next;
    end
  end

  assign wr.W_CLKEN = w_clken;
  assign wr.W_ADDR  = wbin[ADDR_WIDTH-1:0];
  assign wr.W_FULL  = w_full;
  assign wr.W_LEVEL = wbin - rbin;
  assign W_PTR_GRAY = wgray;

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam int            DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] level_next;
  logic          w_almost_full;

  // Same stale rq2 as full, so this flag can only run early, never late.
  assign level_next = wbin_next - rbin;

  always_ff @(posedge W_CLK) begin
    if (W_RST) begin
      w_almost_full <= 1'b0;
    end else begin
      w_almost_full <= (level_next >= AF_THRESH);
    end
  end

  assign wr.W_ALMOST_FULL = w_almost_full;
`else
  // Almost-full disabled: no port and no logic.
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl (ADDR_WIDTH=3, AF_MARGIN=2): reset, fill, overflow, drain, wrap, mid-reset.
module tb_fifo_wr_ctrl;

  localparam int AW = 3;

  logic          W_CLK = 1'b0;
  logic          W_RST;
  logic [AW:0]   R_PTR_GRAY;
  logic [AW:0]   W_PTR_GRAY;
  logic [AW:0]   prev_gray;
  int            errors = 0;
  int            checks = 0;

  fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) wr ();

  fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AF_MARGIN(2)) dut (
    .W_CLK      (W_CLK),
    .W_RST      (W_RST),
    .wr         (wr),
    .R_PTR_GRAY (R_PTR_GRAY),
    .W_PTR_GRAY (W_PTR_GRAY)
  );

  always #5 W_CLK = ~W_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge W_CLK);
    #1;
  endtask

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a concurrent write request
    W_RST      = 1'b1;
    wr.W_INC   = 1'b1;
    R_PTR_GRAY = '0;
    #1;
    check("rst_clken", wr.W_CLKEN, 0);
    tick();
    check("rst_addr",  wr.W_ADDR, 0);
    check("rst_gray",  W_PTR_GRAY, 4'b0000);
    check("rst_full",  wr.W_FULL, 0);
    check("rst_level", wr.W_LEVEL, 0);
`ifdef FIFO_WR_ALMOST_FULL_EN
    check("rst_af",    wr.W_ALMOST_FULL, 0);
`endif

    // Fill 8 entries with the reader parked at 0
    W_RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("fill_clken", wr.W_CLKEN, 1);
      check("fill_addr",  wr.W_ADDR, i);
      tick();
      check("fill_full",  wr.W_FULL, (i == 7));
      check("fill_level", wr.W_LEVEL, i + 1);
`ifdef FIFO_WR_ALMOST_FULL_EN
      check("fill_af",    wr.W_ALMOST_FULL, (i >= 5));
`endif
    end
    check("fill_gray", W_PTR_GRAY, 4'b1100);

    // Overflow attempts are dropped
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ovf_clken", wr.W_CLKEN, 0);
      tick();
      check("ovf_gray",  W_PTR_GRAY, 4'b1100);
      check("ovf_full",  wr.W_FULL, 1);
      check("ovf_addr",  wr.W_ADDR, 0);
    end

    // Reader advances by one: level after 2 edges, full clears on the 3rd
    wr.W_INC   = 1'b0;
    R_PTR_GRAY = 4'b0001;
    tick();
    check("drain_full_e1",  wr.W_FULL, 1);
    check("drain_level_e1", wr.W_LEVEL, 8);
    tick();
    check("drain_full_e2",  wr.W_FULL, 1);
    check("drain_level_e2", wr.W_LEVEL, 7);
    tick();
    check("drain_full_e3",  wr.W_FULL, 0);

    // Clean restart before the wrap run
    W_RST      = 1'b1;
    R_PTR_GRAY = '0;
    tick();
    W_RST = 1'b0;
    check("rst2_level", wr.W_LEVEL, 0);
    check("rst2_gray",  W_PTR_GRAY, 4'b0000);

    // 16 writes, reader trailing by one: full lap, one Gray bit per step
    prev_gray = 4'b0000;
    wr.W_INC  = 1'b1;
    for (int w = 0; w < 16; w++) begin
      R_PTR_GRAY = gray((w > 0) ? w - 1 : 0);
      #1;
      check("wrap_clken", wr.W_CLKEN, 1);
      check("wrap_addr",  wr.W_ADDR, w % 8);
      tick();
      check("wrap_gray",  W_PTR_GRAY, gray(w + 1));
      check("wrap_1bit",  $countones(W_PTR_GRAY ^ prev_gray), 1);
      check("wrap_full",  wr.W_FULL, 0);
      prev_gray = W_PTR_GRAY;
    end
    check("wrap_end_gray", W_PTR_GRAY, 4'b0000);
    check("wrap_end_addr", wr.W_ADDR, 0);

    // Five more writes, then reset while W_INC is still high
    for (int w = 16; w < 21; w++) begin
      R_PTR_GRAY = gray((w - 1) % 16);
      #1;
      check("mid_addr", wr.W_ADDR, w % 8);
      tick();
    end
    check("mid_gray_pre", W_PTR_GRAY, gray(5));
    W_RST      = 1'b1;
    R_PTR_GRAY = '0;
    #1;
    check("mid_rst_clken", wr.W_CLKEN, 0);
    tick();
    check("mid_rst_addr",  wr.W_ADDR, 0);
    check("mid_rst_gray",  W_PTR_GRAY, 4'b0000);
    check("mid_rst_full",  wr.W_FULL, 0);
    check("mid_rst_level", wr.W_LEVEL, 0);
    W_RST    = 1'b0;
    wr.W_INC = 1'b0;
    tick();
    check("post_rst_level", wr.W_LEVEL, 0);
    check("post_rst_gray",  W_PTR_GRAY, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
